// File: rtl/vga_scaled_raster_if.sv
// vga_scaled_raster_if: pixel-side bundle between the raster generator, the
// framebuffer/text sources and the display. The raster block is the master.
interface vga_scaled_raster_if #(
  parameter int ADDRW  = 15,
  parameter int COLORW = 4
);
  logic [1:0]          mode;
  logic [3*COLORW-1:0] rgb_static;
  logic [3*COLORW-1:0] rgb_auto;
  logic [ADDRW-1:0]    fb_addr;
  logic                fb_rd_en;
  logic                datasource;
  logic                frame_start;
  logic [COLORW-1:0]   r_data;
  logic [COLORW-1:0]   g_data;
  logic [COLORW-1:0]   b_data;
  logic                oHS;
  logic                oVS;
  logic                oBLANK_n;

  modport master (
    input  mode, rgb_static, rgb_auto,
    output fb_addr, fb_rd_en, datasource, frame_start,
           r_data, g_data, b_data, oHS, oVS, oBLANK_n
  );

  modport slave (
    output mode, rgb_static, rgb_auto,
    input  fb_addr, fb_rd_en, datasource, frame_start,
           r_data, g_data, b_data, oHS, oVS, oBLANK_n
  );
endinterface

// File: rtl/vga_scaled_raster.sv
// vga_scaled_raster: VGA timing generator that walks a down-scaled framebuffer
// without a multiplier, picks the pixel source per frame, and aligns syncs and
// blanking with the framebuffer read latency.
module vga_scaled_raster #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDRW       = 15,
  parameter int COLORW      = 4,
  parameter int RD_LAT      = 1,
  parameter int WIN_X0      = 0,
  parameter int WIN_X1      = 640,
  parameter int WIN_Y0      = 400,
  parameter int WIN_Y1      = 480
) (
  input  logic                iVGA_CLK,
  input  logic                rst,
  vga_scaled_raster_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL + 1);
  localparam int VCW     = $clog2(V_TOTAL + 1);
  localparam int SW      = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam int CW      = 3 * COLORW;

  localparam logic [HCW-1:0]   H_LAST      = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0]   H_ACT       = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0]   H_ACT_LAST  = HCW'(H_ACTIVE - 1);
  localparam logic [HCW-1:0]   HS_BEG      = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0]   HS_END      = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCW-1:0]   WX_BEG      = HCW'(WIN_X0);
  localparam logic [HCW-1:0]   WX_SPAN     = HCW'(WIN_X1 - WIN_X0);
  localparam logic [VCW-1:0]   V_LAST      = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0]   V_ACT       = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0]   VS_BEG      = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0]   VS_END      = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCW-1:0]   WY_BEG      = VCW'(WIN_Y0);
  localparam logic [VCW-1:0]   WY_SPAN     = VCW'(WIN_Y1 - WIN_Y0);
  localparam logic [SW-1:0]    SUB_MAX     = SW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDRW-1:0] LINE_STRIDE = ADDRW'(H_ACTIVE >> SCALE_SHIFT);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_MIX    = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_e;

  // Sideband that has to travel alongside the framebuffer read.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic ds;
    logic m3;
  } tap_t;

  localparam tap_t TAP_RST = '{hs: 1'b1, vs: 1'b1, act: 1'b0, ds: 1'b0, m3: 1'b0};

  logic [HCW-1:0]   h_q, h_d;
  logic [VCW-1:0]   v_q, v_d;
  logic [SW-1:0]    sub_h_q, sub_h_d;
  logic [SW-1:0]    sub_v_q, sub_v_d;
  logic [ADDRW-1:0] line_base_q, line_base_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  mode_e            mode_q;
  tap_t             dl_q [RD_LAT];
  logic             hs_q, vs_q, blank_n_q;
  logic [CW-1:0]    rgb_q;

  logic h_end, v_end, active_w, active_d, frame_start_w;
  logic hs_raw, vs_raw, in_win, ds_w;
  tap_t tap_in, tap_out;

  assign h_end         = (h_q == H_LAST);
  assign v_end         = (v_q == V_LAST);
  assign active_w      = (h_q < H_ACT) && (v_q < V_ACT);
  assign frame_start_w = (h_q == '0) && (v_q == '0);
  assign hs_raw        = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_raw        = !((v_q >= VS_BEG) && (v_q < VS_END));
  // Wrapping subtraction turns each half-open range test into one compare,
  // which stays well-formed when a window edge sits at zero.
  assign in_win        = ((h_q - WX_BEG) < WX_SPAN) && ((v_q - WY_BEG) < WY_SPAN);

  // Source select for the current pixel, from the per-frame shadow mode.
  always_comb begin
    ds_w = 1'b0;
    case (mode_q)
      MODE_AUTO: ds_w = 1'b1;
      MODE_MIX:  ds_w = in_win;
      default:   ds_w = 1'b0;
    endcase
  end

  // Next position, scaled address walk and line base, without a multiplier.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which is what would otherwise infer a latch.
    h_d         = h_end ? '0 : h_q + 1'b1;
    v_d         = v_q;
    sub_h_d     = (h_end || (sub_h_q == SUB_MAX)) ? '0 : sub_h_q + 1'b1;
    sub_v_d     = sub_v_q;
    line_base_d = line_base_q;
    addr_d      = addr_q;

    if (h_end) begin
      v_d     = v_end ? '0 : v_q + 1'b1;
      sub_v_d = (v_end || (sub_v_q == SUB_MAX)) ? '0 : sub_v_q + 1'b1;
    end

    if (h_end && v_end) begin
      line_base_d = '0;
    end else if ((h_q == H_ACT_LAST) && (v_q < V_ACT) && (sub_v_q == SUB_MAX)) begin
      line_base_d = line_base_q + LINE_STRIDE;
    end

    active_d = (h_d < H_ACT) && (v_d < V_ACT);
    if (active_d) begin
      if (h_d == '0) begin
        addr_d = line_base_d;
      end else if (sub_h_q == SUB_MAX) begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // Timing counters, address registers and the per-frame mode shadow.
  always_ff @(posedge iVGA_CLK or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      h_q         <= '0;
      v_q         <= '0;
      sub_h_q     <= '0;
      sub_v_q     <= '0;
      line_base_q <= '0;
      addr_q      <= '0;
      mode_q      <= MODE_STATIC;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      sub_h_q     <= sub_h_d;
      sub_v_q     <= sub_v_d;
      line_base_q <= line_base_d;
      addr_q      <= addr_d;
      if (frame_start_w) begin
        mode_q <= mode_e'(bus.mode);
      end
    end
  end

  assign tap_in = '{hs: hs_raw, vs: vs_raw, act: active_w, ds: ds_w,
                    m3: (mode_q == MODE_BLANK)};

  // Sideband delay line matching the framebuffer read latency.
  always_ff @(posedge iVGA_CLK or posedge rst) begin
    if (rst) begin
      // NOTE: this array is reset on purpose: it is only a few flops deep and
      // its sync bits must idle high, unlike a data RAM which is left unreset.
      for (int i = 0; i < RD_LAT; i++) begin
        dl_q[i] <= TAP_RST;
      end
    end else begin
      dl_q[0] <= tap_in;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign tap_out = dl_q[RD_LAT-1];

  // Output stage: register syncs, blanking and the selected colour together.
  always_ff @(posedge iVGA_CLK or posedge rst) begin
    if (rst) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= tap_out.hs;
      vs_q      <= tap_out.vs;
      blank_n_q <= tap_out.act;
      if (!tap_out.act || tap_out.m3) begin
        rgb_q <= '0;
      end else if (tap_out.ds) begin
        rgb_q <= bus.rgb_auto;
      end else begin
        rgb_q <= bus.rgb_static;
      end
    end
  end

  // Counters sit at zero during reset, so the read enable is gated explicitly.
  assign bus.fb_addr     = addr_q;
  assign bus.fb_rd_en    = active_w & ~rst;
  assign bus.datasource  = ds_w;
  assign bus.frame_start = frame_start_w;
  assign bus.r_data      = rgb_q[COLORW-1:0];
  assign bus.g_data      = rgb_q[2*COLORW-1:COLORW];
  assign bus.b_data      = rgb_q[3*COLORW-1:2*COLORW];
  assign bus.oHS         = hs_q;
  assign bus.oVS         = vs_q;
  assign bus.oBLANK_n    = blank_n_q;

endmodule
